ga23_cpu_bridge: RTL
====================

# ga23_cpu_bridge

CPU-side initiator for the GA23 tilemap controller's VRAM window. Accepts byte-enabled word requests from the main CPU bus and converts them into GA23's single-strobe `mem_cs`/`mem_rd`/`mem_wr` + `busy` handshake. GA23 only performs full-word writes, so partial-byte writes are handled as read-modify-write. The block sits between the CPU address decoder and GA23, in the `clk` domain.

## Interface
Parameters:
- `TIMEOUT`, 1024, maximum cycles `busy` may stay high in one access before abort.

Ports (one clock `clk`; reset `reset` is synchronous, active-high):
- `clk`  in  1  system clock, same as GA23 `clk`.
- `reset`  in  1  synchronous active-high reset.
- `cpu_req`  in  1  request; sampled only in IDLE.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  16  byte address within the VRAM window; bit 0 ignored.
- `cpu_be`  in  2  byte enables; [0] = low byte, [1] = high byte.
- `cpu_din`  in  16  write data.
- `cpu_dout`  out  16  read data; valid while `cpu_ack`=1.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  qualifies `cpu_ack`: access timed out.
- `mem_cs`, `mem_rd`, `mem_wr`  out  1 each  GA23 access strobes.
- `mem_addr`  out  16  to GA23 `addr`.
- `mem_dout`  out  16  to GA23 `cpu_din`.
- `mem_din`  in  16  from GA23 `cpu_dout`.
- `busy`  in  1  from GA23 `busy`.

## Operation
- Reset: all outputs 0; state IDLE; timeout counter 0.
- States: IDLE, ISSUE, ARM, WAIT, MERGE, DONE.
- IDLE: if `cpu_req`, latch `cpu_we`, `cpu_addr`, `cpu_be`, `cpu_din`.
  - Write with `be`=00: go to DONE; no bus access.
  - Write with `be`=11: full write.
  - Write with `be`=01/10: read phase first (RMW).
  - Read: `be` ignored; full word returned.
- ISSUE: drive `mem_cs`=1 and exactly one of `mem_rd`/`mem_wr`, for exactly one cycle. A longer strobe re-triggers GA23. Next state ARM.
- ARM: strobes 0; `busy` is not examined. Next state WAIT.
- WAIT: while `busy`=1, increment the counter.
  - On `busy`=0: capture `mem_din` into the read register.
  - If in the RMW read phase, go to MERGE; otherwise go to DONE.
- MERGE: build the write word: bytes with `be`=1 come from latched `cpu_din`, the other bytes from the captured word. Return to ISSUE as a write.
- DONE: `cpu_ack`=1 for one cycle, then IDLE.
  - `cpu_dout` = captured word for reads; 0 for writes.
- Bus hold: `mem_addr` and `mem_dout` are held from ISSUE until the state leaves WAIT. GA23 samples them late, at its slot 6.
- Timeout: if the counter reaches `TIMEOUT` in WAIT, go to DONE with `cpu_err`=1 and `cpu_dout`=16'hFFFF. An RMW write is not performed. The counter clears on each ISSUE.
- `cpu_req` is ignored outside IDLE. A new request may be accepted in the cycle after `cpu_ack`.
- Reset mid-access: return to IDLE on the next edge. Strobes drop at once and no ack is issued. GA23 completes its pending slot harmlessly.

## Timing
- Strobes are registered. ISSUE is the cycle after the acceptance edge.
- `busy` rises the cycle after the strobe. ARM masks that cycle, so `busy`=0 seen in WAIT always means completion.
- Read/full write, best case (GA23 `ce`=1, slot 6 aligned): `cpu_ack` in the 5th cycle after acceptance.
- Worst case: bounded by GA23 slot rotation plus the 16-slot rowscroll burst.
- RMW: read latency + 1 (MERGE) + write latency.
- `cpu_dout`/`cpu_err` are valid only while `cpu_ack`=1.

## Structure
- Shared package `ga23_pkg`:
  - state enum `ga23_br_state_t`;
  - byte-merge function `ga23_merge(old, new, be)`;
  - constant `GA23_RD_FILL` = 16'hFFFF.
- Single flat module; no sub-module. The FSM, counter and merge logic are small.

## Test plan
- Responder model holds `busy` 3 cycles and returns 16'h1234. Read at 16'h0100 -> one `mem_rd` pulse with `mem_addr`=16'h0100; `cpu_ack` with `cpu_dout`=16'h1234, `cpu_err`=0.
- Full write, `be`=11, `cpu_din`=16'hBEEF, addr 16'h0202 -> exactly one `mem_wr` pulse with `mem_dout`=16'hBEEF; no `mem_rd`; one `cpu_ack`.
- RMW: model word 16'hAA55; write `be`=10 with `cpu_din`=16'h12FF -> `mem_rd`, then `mem_wr` with `mem_dout`=16'h1255. With `be`=01 -> 16'hAAFF.
- `be`=00 write -> no strobes; `cpu_ack` in the 2nd cycle after acceptance.
- `TIMEOUT`=16, `busy` stuck high -> `cpu_ack` with `cpu_err`=1 and `cpu_dout`=16'hFFFF after 16 WAIT cycles; next request is served normally.
- `reset` pulsed during WAIT -> all outputs 0 next cycle; no `cpu_ack`; `cpu_req` held high during reset is accepted after release.

Source files
------------

// File: rtl/ga23_pkg.sv
// Shared types and helpers for the GA23 CPU-side VRAM bridge.
package ga23_pkg;

  typedef enum logic [2:0] {
    BR_IDLE,
    BR_ISSUE,
    BR_ARM,
    BR_WAIT,
    BR_MERGE,
    BR_DONE
  } ga23_br_state_t;

  // Read data returned on an aborted (timed-out) access.
  localparam logic [15:0] GA23_RD_FILL = 16'hFFFF;

  // Byte-merge: enabled bytes come from new_w, the rest from old_w.
  function automatic logic [15:0] ga23_merge(input logic [15:0] old_w,
                                             input logic [15:0] new_w,
                                             input logic [1:0]  be);
    logic [15:0] w;
    w = old_w;
    if (be[0]) w[7:0]  = new_w[7:0];
    if (be[1]) w[15:8] = new_w[15:8];
    return w;
  endfunction

endpackage

// File: rtl/ga23_cpu_bridge.sv
// CPU-side initiator for the GA23 VRAM window: converts byte-enabled word
// requests into GA23 single-cycle strobes, doing read-modify-write for
// partial-byte writes and aborting accesses whose busy exceeds TIMEOUT.
module ga23_cpu_bridge
  import ga23_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        mem_cs,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_dout,
  input  logic [15:0] mem_din,
  input  logic        busy
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ga23_br_state_t r_state, w_next;

  logic             r_we;
  logic [15:0]      r_addr;
  logic [1:0]       r_be;
  logic [15:0]      r_din;
  logic [15:0]      r_rdata;
  logic [15:0]      r_wdata;
  logic             r_rmw;
  logic             r_op_wr;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cs;
  logic             r_rd;
  logic             r_wr;

  logic             w_issue_wr;
  logic             w_timeout;
  logic             w_active;

  // Next-state decode, including the type of the next bus operation
  always_comb begin
    w_next     = r_state;
    w_issue_wr = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      BR_IDLE: begin
        if (cpu_req) begin
          if (cpu_we && (cpu_be == 2'b00)) begin
            w_next = BR_DONE;
          end else begin
            w_next     = BR_ISSUE;
            w_issue_wr = cpu_we && (cpu_be == 2'b11);
          end
        end
      end
      BR_ISSUE: w_next = BR_ARM;
      BR_ARM:   w_next = BR_WAIT;
      BR_WAIT: begin
        if (!busy) begin
          w_next = r_rmw ? BR_MERGE : BR_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_next    = BR_DONE;
          w_timeout = 1'b1;
        end
      end
      BR_MERGE: begin
        w_next     = BR_ISSUE;
        w_issue_wr = 1'b1;
      end
      BR_DONE:  w_next = BR_IDLE;
      default:  w_next = BR_IDLE;
    endcase
  end

  // State register, registered strobes, request latch, counter and data path
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BR_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_din   <= '0;
      r_rdata <= '0;
      r_wdata <= '0;
      r_rmw   <= 1'b0;
      r_op_wr <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_cs    <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cs    <= (w_next == BR_ISSUE);
      r_rd    <= (w_next == BR_ISSUE) && !w_issue_wr;
      r_wr    <= (w_next == BR_ISSUE) && w_issue_wr;
      case (r_state)
        BR_IDLE: begin
          if (cpu_req) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr & 16'hFFFE;
            r_be    <= cpu_be;
            r_din   <= cpu_din;
            r_wdata <= cpu_din;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_rmw   <= cpu_we && ((cpu_be == 2'b01) || (cpu_be == 2'b10));
            r_op_wr <= cpu_we && (cpu_be == 2'b11);
          end
        end
        BR_ISSUE: r_cnt <= '0;
        BR_WAIT: begin
          if (!busy) begin
            r_rdata <= mem_din;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        BR_MERGE: begin
          r_wdata <= ga23_merge(r_rdata, r_din, r_be);
          r_op_wr <= 1'b1;
          r_rmw   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Address/data stay stable from ISSUE through WAIT since GA23 samples late.
  assign w_active = (r_state == BR_ISSUE) || (r_state == BR_ARM) || (r_state == BR_WAIT);

  assign mem_cs   = r_cs;
  assign mem_rd   = r_rd;
  assign mem_wr   = r_wr;
  assign mem_addr = w_active ? r_addr : '0;
  assign mem_dout = (w_active && r_op_wr) ? r_wdata : '0;

  assign cpu_ack  = (r_state == BR_DONE);
  assign cpu_err  = cpu_ack && r_err;
  assign cpu_dout = !cpu_ack ? '0 :
                    r_err    ? GA23_RD_FILL :
                    r_we     ? '0 : r_rdata;

endmodule
